// File: rtl/md_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_sched_ctrl
// Purpose  : Sequencer for the M-extension multiply/divide resources. It
//            launches the fixed-latency multiplier or the iterative divider,
//            stalls the pipeline until the result exists, and presents a
//            one-cycle result-valid with write data. Divide-by-zero and
//            signed overflow resolve locally. A flush aborts work in flight.
// Ports    : clk, rst_n (sync, active-low)
//            de2ex_inst_valid_ffout, de2ex_MD_OP_ffout, md_funct3,
//            de2ex_rd_oprand1_ffout / de2ex_rd_oprand2_ffout  -- instruction
//            flush                                           -- kill
//            mul_result, div_done, div_quo, div_rem          -- unit results
//            ex2mul_start, ex2mul_op, ex2div_start,
//            ex2div_signed, div_kill                         -- unit control
//            md_stall, ex2mem_mulvalid, div2mem_divvalid,
//            md_wdata                                        -- pipeline side
// Config   : MD_DIV_REUSE_EN -- one-entry divide result reuse cache.
// Revision : 1.0 - initial release
// ============================================================================
module md_sched_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de2ex_inst_valid_ffout,
  input  logic        de2ex_MD_OP_ffout,
  input  logic [2:0]  md_funct3,
  input  logic [31:0] de2ex_rd_oprand1_ffout,
  input  logic [31:0] de2ex_rd_oprand2_ffout,
  input  logic        flush,
  input  logic [31:0] mul_result,
  input  logic        div_done,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  output logic        ex2mul_start,
  output logic [1:0]  ex2mul_op,
  output logic        ex2div_start,
  output logic        ex2div_signed,
  output logic        div_kill,
  output logic        md_stall,
  output logic        ex2mem_mulvalid,
  output logic        div2mem_divvalid,
  output logic [31:0] md_wdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] result;
  logic        res_is_div;
  logic        res_is_rem;

  logic        launch;
  logic        op_is_div;
  logic        op_signed;
  logic        op_is_rem;
  logic        div_by_zero;
  logic        div_ovf;
  logic        div_special;
  logic [31:0] special_res;
  logic        reuse_hit;
  logic [31:0] reuse_res;
  logic        done_ok;

  assign op_is_div   = md_funct3[2];
  assign op_signed   = ~md_funct3[0];
  assign op_is_rem   = md_funct3[1];
  assign div_by_zero = (de2ex_rd_oprand2_ffout == 32'h0);
  assign div_ovf     = op_signed & (de2ex_rd_oprand1_ffout == 32'h8000_0000) &
                       (de2ex_rd_oprand2_ffout == 32'hFFFF_FFFF);
  assign div_special = div_by_zero | div_ovf;

  // Zero divisor wins over overflow; the two cannot coincide anyway.
  assign special_res = div_by_zero ? (op_is_rem ? de2ex_rd_oprand1_ffout : 32'hFFFF_FFFF)
                                   : (op_is_rem ? 32'h0 : 32'h8000_0000);

`ifdef MD_DIV_REUSE_EN
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] cache_op1;
  logic [31:0] cache_op2;
  logic        cache_signed;
  logic [31:0] cache_quo;
  logic [31:0] cache_rem;
  logic        cache_valid;

  assign reuse_hit = cache_valid & (cache_op1 == de2ex_rd_oprand1_ffout) &
                     (cache_op2 == de2ex_rd_oprand2_ffout) & (cache_signed == op_signed);
  assign reuse_res = op_is_rem ? cache_rem : cache_quo;
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = 32'h0;
`endif

  // rst_n gates the combinational pulses so a reset cycle never launches or kills.
  assign launch       = rst_n & (state == IDLE) & de2ex_inst_valid_ffout &
                        de2ex_MD_OP_ffout & ~flush;
  assign ex2mul_start = launch & ~op_is_div;
  assign ex2div_start = launch & op_is_div & ~div_special & ~reuse_hit;
  assign div_kill     = rst_n & (state == DIV_WAIT) & flush;
  assign md_stall     = launch | (state == MUL_WAIT) | (state == DIV_WAIT);

  assign done_ok          = rst_n & (state == DONE) & ~flush;
  assign ex2mem_mulvalid  = done_ok & ~res_is_div;
  assign div2mem_divvalid = done_ok & res_is_div;
  assign md_wdata         = done_ok ? result : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'h0;
      result        <= 32'h0;
      res_is_div    <= 1'b0;
      res_is_rem    <= 1'b0;
      ex2mul_op     <= 2'b00;
      ex2div_signed <= 1'b0;
`ifdef MD_DIV_REUSE_EN
      op1_q         <= 32'h0;
      op2_q         <= 32'h0;
      cache_op1     <= 32'h0;
      cache_op2     <= 32'h0;
      cache_signed  <= 1'b0;
      cache_quo     <= 32'h0;
      cache_rem     <= 32'h0;
      cache_valid   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            res_is_div <= op_is_div;
            res_is_rem <= op_is_rem;
            if (!op_is_div) begin
              ex2mul_op <= md_funct3[1:0];
              cnt       <= CNT_INIT;
              state     <= MUL_WAIT;
            end else if (div_special) begin
              result <= special_res;
              state  <= DONE;
            end else if (reuse_hit) begin
              result <= reuse_res;
              state  <= DONE;
            end else begin
              ex2div_signed <= op_signed;
`ifdef MD_DIV_REUSE_EN
              op1_q <= de2ex_rd_oprand1_ffout;
              op2_q <= de2ex_rd_oprand2_ffout;
`endif
              state <= DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == 4'h0) begin
            result <= mul_result;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        DIV_WAIT: begin
          // Flush beats a same-cycle div_done: the result is dropped.
          if (flush) begin
            state <= IDLE;
`ifdef MD_DIV_REUSE_EN
            cache_valid <= 1'b0;
`endif
          end else if (div_done) begin
            result <= res_is_rem ? div_rem : div_quo;
            state  <= DONE;
`ifdef MD_DIV_REUSE_EN
            cache_op1    <= op1_q;
            cache_op2    <= op2_q;
            cache_signed <= ex2div_signed;
            cache_quo    <= div_quo;
            cache_rem    <= div_rem;
            cache_valid  <= 1'b1;
`endif
          end
        end
        default: begin
          // DONE never launches, so the retiring instruction is not re-issued.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched_ctrl
// Purpose  : Directed bench for md_sched_ctrl with a mock multiplier, a
//            stimulus-driven divider completion and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic        md_op;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic [31:0] mul_result;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        ex2mul_start;
  logic [1:0]  ex2mul_op;
  logic        ex2div_start;
  logic        ex2div_signed;
  logic        div_kill;
  logic        md_stall;
  logic        ex2mem_mulvalid;
  logic        div2mem_divvalid;
  logic [31:0] md_wdata;

  md_sched_ctrl #(.MUL_LAT(2)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .de2ex_inst_valid_ffout (inst_valid),
    .de2ex_MD_OP_ffout      (md_op),
    .md_funct3              (funct3),
    .de2ex_rd_oprand1_ffout (op1),
    .de2ex_rd_oprand2_ffout (op2),
    .flush                  (flush),
    .mul_result             (mul_result),
    .div_done               (div_done),
    .div_quo                (div_quo),
    .div_rem                (div_rem),
    .ex2mul_start           (ex2mul_start),
    .ex2mul_op              (ex2mul_op),
    .ex2div_start           (ex2div_start),
    .ex2div_signed          (ex2div_signed),
    .div_kill               (div_kill),
    .md_stall               (md_stall),
    .ex2mem_mulvalid        (ex2mem_mulvalid),
    .div2mem_divvalid       (div2mem_divvalid),
    .md_wdata               (md_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    else
      passes++;
  endtask

  // Mock multiplier: product is presented only in the cycle MUL_LAT=2 after start.
  logic [1:0]  mst = 2'b00;
  logic [31:0] mprod = 32'h0;
  always @(posedge clk) begin
    mst <= {mst[0], ex2mul_start};
    if (ex2mul_start) mprod <= op1 * op2;
  end
  assign mul_result = mst[1] ? mprod : 32'hDEAD_BEEF;

  // Stall run-length monitor.
  int stall_run  = 0;
  int last_stall = 0;
  always @(negedge clk) begin
    if (md_stall) stall_run++;
    else begin
      if (stall_run != 0) last_stall = stall_run;
      stall_run = 0;
    end
  end

  typedef struct {
    bit          is_div;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Scoreboard monitor: every valid pops one expectation.
  always @(negedge clk) begin
    if (ex2mem_mulvalid || div2mem_divvalid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got mul=%0b div=%0b data=0x%08h expected no valid at cycle %0d",
                 ex2mem_mulvalid, div2mem_divvalid, md_wdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_class_div", {31'h0, div2mem_divvalid}, {31'h0, e.is_div});
        check("valid_class_mul", {31'h0, ex2mem_mulvalid}, {31'h0, ~e.is_div});
        check("valid_data", md_wdata, e.data);
        check("valid_cycle", cyc, e.cyc);
      end
    end else begin
      check("wdata_idle_zero", md_wdata, 32'h0);
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input bit exp_dstart, input int div_lat,
                        input logic [31:0] quo, input logic [31:0] rem, input logic [31:0] exp_data);
    exp_t e;
    last_stall = 0;
    @(posedge clk); #1;
    inst_valid = 1'b1; md_op = 1'b1; funct3 = f3; op1 = a; op2 = b;
    @(negedge clk);
    e.is_div = f3[2]; e.data = exp_data; e.cyc = cyc + exp_stall;
    sb.push_back(e);
    if (f3[2]) check("div_start", {31'h0, ex2div_start}, {31'h0, exp_dstart});
    else       check("mul_start", {31'h0, ex2mul_start}, 32'h1);
    check("stall_launch", {31'h0, md_stall}, 32'h1);
    @(posedge clk); #1;
    inst_valid = 1'b0; md_op = 1'b0;
    if (f3[2] && exp_dstart) begin
      check("div_signed", {31'h0, ex2div_signed}, {31'h0, ~f3[0]});
      repeat (div_lat - 1) @(posedge clk);
      #1; div_done = 1'b1; div_quo = quo; div_rem = rem;
      @(posedge clk); #1; div_done = 1'b0;
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL result_timeout: got no valid expected one for funct3=%0d", f3);
      sb.delete();
    end
    @(negedge clk);
    check("stall_len", last_stall, exp_stall);
  endtask

  // Launch, then assert flush k cycles later (optionally with div_done).
  task automatic flush_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int k, input bit with_done, input bit exp_kill);
    @(posedge clk); #1;
    inst_valid = 1'b1; md_op = 1'b1; funct3 = f3; op1 = a; op2 = b;
    @(posedge clk); #1;
    inst_valid = 1'b0; md_op = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1; flush = 1'b1; div_done = with_done; div_quo = 32'h1234; div_rem = 32'h5678;
    @(negedge clk);
    check("div_kill", {31'h0, div_kill}, {31'h0, exp_kill});
    @(posedge clk); #1; flush = 1'b0; div_done = 1'b0;
    @(negedge clk);
    check("stall_after_flush", {31'h0, md_stall}, 32'h0);
    if (!with_done) begin
      repeat (2) @(posedge clk);
      #1; div_done = 1'b1;
      @(posedge clk); #1; div_done = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; md_op = 1'b0; funct3 = 3'b000;
    op1 = 32'h0; op2 = 32'h0; flush = 1'b0; div_done = 1'b0;
    div_quo = 32'h0; div_rem = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, md_stall}, 32'h0);
    check("rst_mulvalid", {31'h0, ex2mem_mulvalid}, 32'h0);
    check("rst_divvalid", {31'h0, div2mem_divvalid}, 32'h0);
    check("rst_mul_op", {30'h0, ex2mul_op}, 32'h0);
    check("rst_div_signed", {31'h0, ex2div_signed}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Flush in IDLE blocks the launch.
    @(posedge clk); #1;
    inst_valid = 1'b1; md_op = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd3; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", {31'h0, md_stall}, 32'h0);
    check("idle_flush_start", {31'h0, ex2mul_start}, 32'h0);
    @(posedge clk); #1; inst_valid = 1'b0; md_op = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 3, 1'b0, 0, 0, 0, 32'hFFFF_FFEB);
    run_op(3'b000, 32'h0001_0001, 32'h0000_FFFF, 3, 1'b0, 0, 0, 0, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd7, 34, 1'b1, 33, 32'd14, 32'd2, 32'd14);
    run_op(3'b100, 32'd5, 32'd0, 1, 1'b0, 0, 0, 0, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd5, 32'd0, 1, 1'b0, 0, 0, 0, 32'd5);
    run_op(3'b111, 32'd0, 32'd0, 1, 1'b0, 0, 0, 0, 32'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0, 0, 0, 0, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0, 0, 0, 0, 32'h0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1'b1, 3, 32'h0, 32'h8000_0000, 32'h0);
    run_op(3'b100, 32'd100, 32'd7, 6, 1'b1, 5, 32'd14, 32'd2, 32'd14);
`ifdef MD_DIV_REUSE_EN
    run_op(3'b110, 32'd100, 32'd7, 1, 1'b0, 0, 0, 0, 32'd2);
`else
    run_op(3'b110, 32'd100, 32'd7, 5, 1'b1, 4, 32'd14, 32'd2, 32'd2);
`endif

    // Flush 5 cycles into DIV_WAIT; the cache must not serve the next DIV 100/7.
    flush_op(3'b100, 32'd200, 32'd9, 5, 1'b0, 1'b1);
    run_op(3'b100, 32'd100, 32'd7, 5, 1'b1, 4, 32'd14, 32'd2, 32'd14);

    // Reset while in MUL_WAIT.
    @(posedge clk); #1;
    inst_valid = 1'b1; md_op = 1'b1; funct3 = 3'b011; op1 = 32'd4; op2 = 32'd5;
    @(posedge clk); #1;
    inst_valid = 1'b0; md_op = 1'b0;
    check("mul_op_reg", {30'h0, ex2mul_op}, 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_stall", {31'h0, md_stall}, 32'h0);
    check("rst_mid_mul_op", {30'h0, ex2mul_op}, 32'h0);
    check("rst_mid_div_signed", {31'h0, ex2div_signed}, 32'h0);
    check("rst_mid_kill", {31'h0, div_kill}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) @(negedge clk);

    flush_op(3'b101, 32'd9, 32'd2, 3, 1'b1, 1'b1);
    flush_op(3'b000, 32'd2, 32'd3, 3, 1'b0, 1'b0);
    run_op(3'b000, 32'd3, 32'd4, 3, 1'b0, 0, 0, 0, 32'd12);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
